// File: rtl/clock_div_by3.sv
// ---------------------------------------------------------------------------
// clock_div_by3
//   Glitch-free integer clock divider producing a 50 % duty-cycle clock at
//   clock_in / DIV. For odd DIV a falling-edge copy of the rising-edge phase
//   register stretches the high phase by half an input period. For even DIV
//   only rising-edge logic is used.
//
// Parameters
//   DIV        division ratio, 2..65535 (default 3)
//
// Ports
//   clock_in   input   fast input clock
//   reset_n    input   asynchronous active-low reset
//   clock_out  output  divided clock, first rising edge on the first
//                      rising edge of clock_in after reset release
// ---------------------------------------------------------------------------
module clock_div_by3 #(
   parameter int unsigned DIV = 3
) (
   input  logic clock_in,
   input  logic reset_n,
   output logic clock_out
);

   localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int unsigned H  = DIV / 2;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(H);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("clock_div_by3: DIV must be at least 2");
      end
   endgenerate

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          run_q;
   logic          pos_q;
   logic          pos_d;

   // run_q marks that the first edge after reset has been taken; that edge
   // loads cnt = 0 rather than advancing, so the output rises on it.
   always_comb begin
      cnt_d = '0;
      if (run_q) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      pos_d = (cnt_d < CNT_HALF);
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         pos_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= 1'b1;
         pos_q <= pos_d;
      end
   end

   generate
      if ((DIV % 2) == 1) begin : g_odd
         logic neg_q;

         // Half-period delayed copy; it overlaps pos_q, so the OR never
         // dips between the two phases.
         always_ff @(negedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
               neg_q <= 1'b0;
            end else begin
               neg_q <= pos_q;
            end
         end

         assign clock_out = pos_q | neg_q;
      end else begin : g_even
         assign clock_out = pos_q;
      end
   endgenerate

endmodule

// File: tb/tb_clock_div_by3.sv
`timescale 1ns/1ps
module tb_clock_div_by3;

   localparam int DIVS [4] = '{2, 3, 4, 5};
   localparam int HALF_NS = 500;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] outs;

   int total = 0;
   int bad   = 0;

   always #HALF_NS clk = ~clk;

   clock_div_by3 #(.DIV(2)) u_div2 (.clock_in(clk), .reset_n(rst_n), .clock_out(outs[0]));
   clock_div_by3 #(.DIV(3)) u_div3 (.clock_in(clk), .reset_n(rst_n), .clock_out(outs[1]));
   clock_div_by3 #(.DIV(4)) u_div4 (.clock_in(clk), .reset_n(rst_n), .clock_out(outs[2]));
   clock_div_by3 #(.DIV(5)) u_div5 (.clock_in(clk), .reset_n(rst_n), .clock_out(outs[3]));

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: k counts input half-periods since the first rising edge
   // seen with reset high (k = 0 at that edge). The output is high for the
   // first DIV half-periods of every 2*DIV.
   int k = -1;
   always @(clk) begin
      logic rising;
      rising = clk;
      #1;
      if (!rst_n) begin
         k = -1;
      end else if (rising && k < 0) begin
         k = 0;
      end else if (k >= 0) begin
         k++;
      end
      for (int i = 0; i < 4; i++) begin
         logic expv;
         expv = (k >= 0) && ((k % (2 * DIVS[i])) < DIVS[i]);
         check($sformatf("model_div%0d", DIVS[i]), outs[i], expv);
      end
   end

   // Edge-timing monitor: period, high and low time of every full phase.
   logic [3:0] outs_prev = 4'b0000;
   longint     last_rise [4];
   longint     last_fall [4];
   bit         has_rise  [4];
   bit         has_fall  [4];

   always @(negedge rst_n) begin
      for (int i = 0; i < 4; i++) begin
         has_rise[i] = 1'b0;
         has_fall[i] = 1'b0;
      end
   end

   always @(outs) begin
      for (int i = 0; i < 4; i++) begin
         if (outs[i] !== outs_prev[i]) begin
            if (rst_n !== 1'b1) begin
               has_rise[i] = 1'b0;
               has_fall[i] = 1'b0;
            end else if (outs[i] === 1'b1) begin
               if (has_rise[i])
                  check($sformatf("period_div%0d", DIVS[i]), $time - last_rise[i], DIVS[i] * 2 * HALF_NS);
               if (has_fall[i])
                  check($sformatf("low_time_div%0d", DIVS[i]), $time - last_fall[i], DIVS[i] * HALF_NS);
               last_rise[i] = $time;
               has_rise[i]  = 1'b1;
            end else begin
               if (has_rise[i])
                  check($sformatf("high_time_div%0d", DIVS[i]), $time - last_rise[i], DIVS[i] * HALF_NS);
               last_fall[i] = $time;
               has_fall[i]  = 1'b1;
            end
         end
      end
      outs_prev = outs;
   end

   // Transition counter used while reset is held.
   bit hold_mon = 1'b0;
   int hold_trans = 0;
   always @(outs) if (hold_mon) hold_trans++;

   int  off;
   bit  found;
   logic was;

   initial begin
      #200;
      check("reset_outs", outs, 4'b0000);

      hold_mon = 1'b1;
      repeat (10) @(posedge clk);
      #100;
      check("reset_hold_trans", hold_trans, 0);
      check("reset_hold_outs", outs, 4'b0000);
      hold_mon = 1'b0;
      rst_n = 1'b1;

      // Hand-computed waveform right after release.
      @(posedge clk); #1;                          // E1
      check("lit_e1_div3", outs[1], 1);
      check("lit_e1_div2", outs[0], 1);
      @(negedge clk); #1;
      check("lit_fall1_div3", outs[1], 1);
      @(posedge clk); #1;                          // E2
      check("lit_e2_div3", outs[1], 1);
      check("lit_e2_div2", outs[0], 0);
      @(negedge clk); #1;
      check("lit_fall2_div3", outs[1], 0);
      @(posedge clk); #1;                          // E3
      check("lit_e3_div3", outs[1], 0);
      check("lit_e3_div4", outs[2], 0);
      check("lit_e3_div5", outs[3], 1);
      @(negedge clk); #1;
      check("lit_fall3_div5", outs[3], 0);
      @(posedge clk); #1;                          // E4
      check("lit_e4_div3", outs[1], 1);

      repeat (20) @(posedge clk);

      // Reset 250 ns after a DIV=3 output rising edge.
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk); #1;
         was = outs[1];
         @(posedge clk); #1;
         if (!was && outs[1]) found = 1'b1;
      end
      check("find_rise_div3", found, 1);
      #249;
      rst_n = 1'b0;
      #1;
      check("mid_reset_async", outs, 4'b0000);
      repeat (2) @(posedge clk);
      #300;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("restart_e1", outs, 4'b1111);

      // Random free-run intervals interrupted by random resets.
      repeat (6) begin
         repeat ($urandom_range(10, 40)) @(posedge clk);
         off = $urandom_range(0, 1) ? $urandom_range(50, 450) : $urandom_range(550, 950);
         #off;
         rst_n = 1'b0;
         #1;
         check("rand_reset_async", outs, 4'b0000);
         repeat ($urandom_range(1, 5)) @(posedge clk);
         off = $urandom_range(0, 1) ? $urandom_range(50, 450) : $urandom_range(550, 950);
         #off;
         rst_n = 1'b1;
      end

      repeat (30) @(posedge clk);
      #10;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
